// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request/response handshake bundle for alu_issue_ctrl.
//   req_*  : requester -> controller (operands, opcode, tag), ready back.
//   rsp_*  : controller -> consumer (result, zero, tag, err), ready back.
//   slave  : modport used by the controller.
//   master : modport used by the requester/consumer side.
interface alu_issue_ctrl_if #(
  parameter int unsigned TW = 4
) ();

  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_a_i;
  logic [31:0]   req_b_i;
  logic [2:0]    req_op_i;
  logic [TW-1:0] req_tag_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_result_o;
  logic          rsp_zero_o;
  logic [TW-1:0] rsp_tag_o;
  logic          rsp_err_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_op_i, req_tag_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_tag_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_op_i, req_tag_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_tag_o, rsp_err_o
  );

endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues requests to an external registered ALU (1-cycle
// latency), carries tag/err alongside the result, and queues responses in a
// DEPTH-entry FIFO. Credit-based request flow control guarantees the FIFO
// can absorb everything already in flight.
// Ports:
//   clk_i, rst_i        : clock (rising edge), async active-high reset
//   bus (slave)         : request/response handshakes
//   alu_a_o/alu_b_o/alu_ctrl_o : registered operands/control to the ALU
//   alu_result_i/alu_zero_i    : registered ALU outputs
//   flush_i             : synchronous discard of all in-flight and queued work
//   busy_o              : any pipeline valid or FIFO non-empty
module alu_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_issue_ctrl_if.slave      bus,
  output logic [31:0]          alu_a_o,
  output logic [31:0]          alu_b_o,
  output logic [2:0]           alu_ctrl_o,
  input  logic [31:0]          alu_result_i,
  input  logic                 alu_zero_i,
  input  logic                 flush_i,
  output logic                 busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(DEPTH + 3);
  localparam logic [2:0]  OP_ILLEGAL = 3'b101;

  typedef struct packed {
    logic [31:0]   result;
    logic          zero;
    logic [TW-1:0] tag;
    logic          err;
  } rsp_t;

  // Issue stage
  logic [31:0]   alu_a_q, alu_a_d;
  logic [31:0]   alu_b_q, alu_b_d;
  logic [2:0]    alu_ctrl_q, alu_ctrl_d;
  logic          iss_valid_q, iss_valid_d;
  logic [TW-1:0] iss_tag_q, iss_tag_d;
  logic          iss_err_q, iss_err_d;

  // ALU stage shadow
  logic          ex_valid_q, ex_valid_d;
  logic [TW-1:0] ex_tag_q, ex_tag_d;
  logic          ex_err_q, ex_err_d;

  // Response FIFO
  rsp_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          busy_q, busy_d;

  logic          req_ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic          mem_we;
  logic [OW-1:0] occupancy;
  rsp_t          push_data;

  // Credit check on registered state only, so a same-cycle pop never raises ready
  always_comb begin
    occupancy = OW'(iss_valid_q) + OW'(ex_valid_q) + OW'(count_q);
    req_ready = ~rst_i & ~flush_i & (occupancy < OW'(DEPTH));
  end

  assign accept = bus.req_valid_i & req_ready;
  assign push   = ex_valid_q;
  assign pop    = rsp_valid_q & bus.rsp_ready_i;

  // Illegal opcodes return a fixed result independent of what the ALU produced
  always_comb begin
    push_data = '0;
    if (ex_err_q) begin
      push_data.result = 32'd0;
      push_data.zero   = 1'b1;
      push_data.err    = 1'b1;
    end else begin
      push_data.result = alu_result_i;
      push_data.zero   = alu_zero_i;
      push_data.err    = 1'b0;
    end
    push_data.tag = ex_tag_q;
  end

  // Next-state logic for pipeline and FIFO bookkeeping
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    iss_tag_d   = iss_tag_q;
    iss_err_d   = iss_err_q;
    iss_valid_d = accept;
    ex_valid_d  = iss_valid_q;
    ex_tag_d    = iss_tag_q;
    ex_err_d    = iss_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_we      = 1'b0;

    if (accept) begin
      alu_a_d    = bus.req_a_i;
      alu_b_d    = bus.req_b_i;
      alu_ctrl_d = bus.req_op_i;
      iss_tag_d  = bus.req_tag_i;
      iss_err_d  = (bus.req_op_i == OP_ILLEGAL);
    end

    if (push) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flush drops everything but leaves the ALU-facing data registers alone
    if (flush_i) begin
      iss_valid_d = 1'b0;
      ex_valid_d  = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      mem_we      = 1'b0;
    end

    rsp_valid_d = (count_d != '0);
    busy_d      = iss_valid_d | ex_valid_d | (count_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      iss_valid_q <= 1'b0;
      iss_tag_q   <= '0;
      iss_err_q   <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_tag_q    <= '0;
      ex_err_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      iss_valid_q <= iss_valid_d;
      iss_tag_q   <= iss_tag_d;
      iss_err_q   <= iss_err_d;
      ex_valid_q  <= ex_valid_d;
      ex_tag_q    <= ex_tag_d;
      ex_err_q    <= ex_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // FIFO storage; reset to zero so the response outputs read zero out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_result_o = mem_q[rd_ptr_q].result;
  assign bus.rsp_zero_o   = mem_q[rd_ptr_q].zero;
  assign bus.rsp_tag_o    = mem_q[rd_ptr_q].tag;
  assign bus.rsp_err_o    = mem_q[rd_ptr_q].err;
  assign alu_a_o          = alu_a_q;
  assign alu_b_o          = alu_b_q;
  assign alu_ctrl_o       = alu_ctrl_q;
  assign busy_o           = busy_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, response FIFO entries (power of 2, >= 2).
REQ-002 SHALL have parameter TW, default 4, request tag width.
REQ-003 SHALL have port clk_i  input  1  clock; rising-edge active.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  1  request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-007 SHALL have port req_a_i  input  32  operand A.
REQ-008 SHALL have port req_b_i  input  32  operand B.
REQ-009 SHALL have port req_op_i  input  3  ALU control code.
REQ-010 SHALL have port req_tag_i  input  TW  request tag, returned with response.
REQ-011 SHALL have port alu_a_o  output  32  operand A to ALU.
REQ-012 SHALL have port alu_b_o  output  32  operand B to ALU.
REQ-013 SHALL have port alu_ctrl_o  output  3  control code to ALU.
REQ-014 SHALL have port alu_result_i  input  32  registered ALU result, 1-cycle latency.
REQ-015 SHALL have port alu_zero_i  input  1  registered ALU zero flag.
REQ-016 SHALL have port rsp_valid_o  output  1  response valid.
REQ-017 SHALL have port rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-018 SHALL have port rsp_result_o  output  32  result.
REQ-019 SHALL have port rsp_zero_o  output  1  zero flag.
REQ-020 SHALL have port rsp_tag_o  output  TW  tag of the originating request.
REQ-021 SHALL have port rsp_err_o  output  1  illegal opcode flag.
REQ-022 SHALL have port flush_i  input  1  synchronous discard of all in-flight and queued work.
REQ-023 SHALL have port busy_o  output  1  high while any operation is in flight or queued.

Function
REQ-024 Legal opcodes SHALL be 010 ADD, 110 SUB, 000 AND, 001 OR, 011 XOR, 100 NOR, 111 SLT; 101 is illegal.
REQ-025 Request accepted at edge N SHALL drive alu_a_o/alu_b_o/alu_ctrl_o from registers in cycle N+1.
REQ-026 Pipeline SHALL be: issue stage (N+1), ALU stage (N+2, alu_result_i valid), capture into FIFO at edge ending N+2, rsp_valid_o high from cycle N+3 at earliest.
REQ-027 Tag and err bit SHALL travel in a 2-stage shadow pipeline aligned with the ALU result.
REQ-028 Illegal opcode SHALL still be issued as 101; the response SHALL carry rsp_err_o=1, rsp_result_o=0, rsp_zero_o=1 regardless of ALU inputs.
REQ-029 When no request is accepted, alu_ctrl_o SHALL hold its last value and the issue-stage valid bit SHALL clear; no FIFO write occurs for that slot.
REQ-030 Credit rule: req_ready_o SHALL be high iff (in-flight count + FIFO count) < DEPTH, with in-flight counting issue and ALU stages.
REQ-031 req_ready_o SHALL NOT depend combinationally on req_valid_i.
REQ-032 A FIFO pop in the same cycle SHALL not raise req_ready_o in that cycle (ready uses registered counts).
REQ-033 FIFO SHALL never overflow; simultaneous push and pop at full or empty SHALL keep count unchanged and preserve order.
REQ-034 Responses SHALL emerge in request order; rsp_* SHALL hold stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-035 FIFO pointers SHALL wrap modulo DEPTH without loss.
REQ-036 flush_i SHALL clear pipeline valids, FIFO count and pointers at the next edge, override same-cycle request acceptance (req_ready_o low while flush_i high), and leave alu_* data outputs unchanged.
REQ-037 busy_o SHALL equal OR of pipeline valids and (FIFO count != 0).

Reset
REQ-038 On rst_i high, asynchronously: req_ready_o... computed 1 after release, rsp_valid_o=0, rsp_result_o=0, rsp_zero_o=0, rsp_tag_o=0, rsp_err_o=0, alu_a_o=0, alu_b_o=0, alu_ctrl_o=000, busy_o=0, all counts and pointers 0.
REQ-039 Reset mid-operation SHALL discard all in-flight and queued responses; none appear after release.
REQ-040 req_ready_o SHALL be 0 while rst_i is high and 1 in the first cycle after release.

Verification
REQ-041 Single ADD A=5 B=7 tag=3 accepted at edge 0 -> alu_* = 5,7,010 in cycle 1; rsp 12, zero=0, tag=3, valid in cycle 3.
REQ-042 SUB A=9 B=9 then illegal op 101 A=1 B=2 back-to-back -> rsp (0, zero=1, err=0) then (0, zero=1, err=1), in order, consecutive cycles.
REQ-043 rsp_ready_i=0, stream of requests -> exactly DEPTH (4) accepted, req_ready_o low after; release rsp_ready_i -> 4 responses in order, ready returns.
REQ-044 Continuous requests with rsp_ready_i=1 for 20 ops -> wrap-around exercised, one response per cycle, no loss or reorder of tags 0..15 repeating.
REQ-045 flush_i pulse with 2 in flight and 2 queued -> next cycle rsp_valid_o=0, busy_o=0, no stale response later.
REQ-046 rst_i asserted mid-cycle with 3 pending -> outputs zero immediately; after release no response appears, req_ready_o=1.
